// File: rtl/alu_issue_unit.sv
// alu_issue_unit: registered, flow-controlled issue/capture stage around a
// combinational 16-bit ALU with an internal 8x16 register file (r0 reads 0).
// Optional: define ALU_ISSUE_FLAGS_EN to add rsp_zero/rsp_carry outputs.
module alu_issue_unit #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_CNT = 8,
  localparam int unsigned IDX_W = $clog2(REG_CNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [IDX_W-1:0]  cmd_rs1,
  input  logic [IDX_W-1:0]  cmd_rs2,
  input  logic [IDX_W-1:0]  cmd_rd,
  input  logic              ld_valid,
  input  logic [IDX_W-1:0]  ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_control,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [IDX_W-1:0]  rsp_rd,
  output logic              rsp_err
`ifdef ALU_ISSUE_FLAGS_EN
  ,
  output logic              rsp_zero,
  output logic              rsp_carry
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_LAST = 3'b100;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [DATA_W-1:0] regs [REG_CNT];
  logic [IDX_W-1:0]  rd_q;
  logic              accept;
  logic              wb_en;

  assign cmd_ready = (state == IDLE) && !rst;
  assign rsp_valid = (state == RESP);
  assign accept    = cmd_valid && cmd_ready;
  assign wb_en     = (state == RESP) && rsp_ready && !rsp_err && (rsp_rd != '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: one EXEC cycle, then hold RESP until consumed
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Register file: load port first so a same-index writeback overrides it
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < REG_CNT; i++) regs[i] <= '0;
    end else begin
      if (ld_valid && (ld_addr != '0)) regs[ld_addr] <= ld_data;
      if (wb_en) regs[rsp_rd] <= rsp_data;
    end
  end

  // Operand latch at accept; result capture at the end of EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= '0;
      rd_q        <= '0;
      rsp_data    <= '0;
      rsp_rd      <= '0;
      rsp_err     <= 1'b0;
    end else begin
      if (accept) begin
        alu_a       <= regs[cmd_rs1];
        alu_b       <= regs[cmd_rs2];
        alu_control <= cmd_op;
        rd_q        <= cmd_rd;
      end
      if (state == EXEC) begin
        rsp_data <= alu_result;
        rsp_rd   <= rd_q;
        rsp_err  <= (alu_control > OP_LAST);
      end
    end
  end

`ifdef ALU_ISSUE_FLAGS_EN
  logic [DATA_W:0] add_sum;
  logic            carry_c;

  // Local carry/borrow, since the ALU itself drops them
  always_comb begin
    add_sum = {1'b0, alu_a} + {1'b0, alu_b};
    carry_c = 1'b0;
    if (alu_control == OP_ADD)      carry_c = add_sum[DATA_W];
    else if (alu_control == OP_SUB) carry_c = (alu_a < alu_b);
  end

  // Flag capture alongside rsp_data
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_zero  <= 1'b0;
      rsp_carry <= 1'b0;
    end else if (state == EXEC) begin
      rsp_zero  <= (alu_result == '0);
      rsp_carry <= carry_c;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_unit.sv
// Testbench for alu_issue_unit: constant vector table, hand-written corner
// sequences, then random traffic against a behavioural register-file model.
module tb_alu_issue_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op, cmd_rs1, cmd_rs2, cmd_rd;
  logic        ld_valid;
  logic [2:0]  ld_addr;
  logic [15:0] ld_data;
  logic [15:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_control;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [15:0] rsp_data;
  logic [2:0]  rsp_rd;
`ifdef ALU_ISSUE_FLAGS_EN
  logic        rsp_zero, rsp_carry;
`endif

  int errors = 0;
  int checks = 0;
  logic [15:0] m_rf [8];

  alu_issue_unit dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_rd(rsp_rd), .rsp_err(rsp_err)
`ifdef ALU_ISSUE_FLAGS_EN
    , .rsp_zero(rsp_zero), .rsp_carry(rsp_carry)
`endif
  );

  always #5 clk = ~clk;

  // Combinational ALU the unit is wrapped around (illegal ops give 0)
  always_comb begin
    case (alu_control)
      3'd0:    alu_result = alu_a + alu_b;
      3'd1:    alu_result = alu_a - alu_b;
      3'd2:    alu_result = alu_a & alu_b;
      3'd3:    alu_result = alu_a | alu_b;
      3'd4:    alu_result = alu_a ^ alu_b;
      default: alu_result = 16'h0000;
    endcase
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_res(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    int unsigned sa = a;
    int unsigned sb = b;
    case (op)
      3'd0:    return 16'((sa + sb) % 65536);
      3'd1:    return 16'((sa + 65536 - sb) % 65536);
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic ref_carry(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    int unsigned sa = a;
    int unsigned sb = b;
    if (op == 3'd0) return (sa + sb) > 65535;
    if (op == 3'd1) return sa < sb;
    return 1'b0;
  endfunction

  // Tasks start and end at a falling edge
  task automatic load(input logic [2:0] a, input logic [15:0] d);
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_valid = 1'b0;
    if (a != 3'd0) m_rf[a] = d;
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] rs1, input logic [2:0] rs2,
                       input logic [2:0] rd, input int stall, input logic ldc,
                       input logic [2:0] la, input logic [15:0] ldd,
                       output logic [15:0] d, output logic e);
    logic [15:0] ea, eb, ex;
    logic        legal;
    int          n;
    n = 0;
    while (!cmd_ready && n < 10) begin @(negedge clk); n++; end
    chk("cmd_ready_idle", 16'(cmd_ready), 16'd1);
    ea = m_rf[rs1]; eb = m_rf[rs2];
    ex = ref_res(op, ea, eb);
    legal = (op <= 3'd4);
    cmd_valid = 1'b1; cmd_op = op; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_rd = rd;
    ld_valid = ldc; ld_addr = la; ld_data = ldd;
    rsp_ready = (stall == 0);
    @(negedge clk);
    cmd_valid = 1'b0; ld_valid = 1'b0;
    if (ldc && la != 3'd0) m_rf[la] = ldd;
    chk("exec_cmd_ready", 16'(cmd_ready), 16'd0);
    chk("exec_rsp_valid", 16'(rsp_valid), 16'd0);
    chk("exec_alu_a", alu_a, ea);
    chk("exec_alu_b", alu_b, eb);
    chk("exec_alu_control", 16'(alu_control), 16'(op));
    @(negedge clk);
    n = 0;
    while (!rsp_valid && n < 8) begin @(negedge clk); n++; end
    chk("rsp_latency", 16'(n), 16'd0);
    d = rsp_data; e = rsp_err;
    chk("rsp_err", 16'(rsp_err), 16'(!legal));
    chk("rsp_rd", 16'(rsp_rd), 16'(rd));
    if (legal) chk("rsp_data", rsp_data, ex);
`ifdef ALU_ISSUE_FLAGS_EN
    chk("rsp_zero", 16'(rsp_zero), 16'(ex == 16'h0000));
    chk("rsp_carry", 16'(rsp_carry), 16'(ref_carry(op, ea, eb)));
`endif
    for (int k = 1; k <= stall; k++) begin
      @(negedge clk);
      chk("stall_valid", 16'(rsp_valid), 16'd1);
      chk("stall_data", rsp_data, d);
      chk("stall_cmd_ready", 16'(cmd_ready), 16'd0);
      if (k == stall) rsp_ready = 1'b1;
    end
    @(negedge clk);
    chk("post_hs_valid", 16'(rsp_valid), 16'd0);
    if (legal && rd != 3'd0) m_rf[rd] = ex;
  endtask

  typedef struct {
    logic        ld;
    logic [15:0] a, b;
    logic [2:0]  op, rs1, rs2, rd;
    logic [15:0] exp;
    logic        z, c;
  } vec_t;

  vec_t        vt [12];
  logic [15:0] d;
  logic        e;

  initial begin
    vt[0]  = '{1'b1, 16'h1234, 16'h5678, 3'd0, 3'd1, 3'd2, 3'd3, 16'h68AC, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 16'h0000, 16'h0000, 3'd3, 3'd3, 3'd0, 3'd4, 16'h68AC, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 16'hFFFF, 16'h0001, 3'd0, 3'd1, 3'd2, 3'd3, 16'h0000, 1'b1, 1'b1};
    vt[3]  = '{1'b0, 16'h0000, 16'h0000, 3'd1, 3'd2, 3'd2, 3'd3, 16'h0000, 1'b1, 1'b0};
    vt[4]  = '{1'b0, 16'h0000, 16'h0000, 3'd1, 3'd2, 3'd1, 3'd3, 16'h0002, 1'b0, 1'b1};
    vt[5]  = '{1'b1, 16'hF0F0, 16'h0F0F, 3'd2, 3'd1, 3'd2, 3'd5, 16'h0000, 1'b1, 1'b0};
    vt[6]  = '{1'b0, 16'h0000, 16'h0000, 3'd3, 3'd1, 3'd2, 3'd5, 16'hFFFF, 1'b0, 1'b0};
    vt[7]  = '{1'b0, 16'h0000, 16'h0000, 3'd4, 3'd1, 3'd2, 3'd5, 16'hFFFF, 1'b0, 1'b0};
    vt[8]  = '{1'b1, 16'hAAAA, 16'h5555, 3'd2, 3'd1, 3'd2, 3'd6, 16'h0000, 1'b1, 1'b0};
    vt[9]  = '{1'b0, 16'h0000, 16'h0000, 3'd3, 3'd1, 3'd2, 3'd6, 16'hFFFF, 1'b0, 1'b0};
    vt[10] = '{1'b0, 16'h0000, 16'h0000, 3'd4, 3'd1, 3'd2, 3'd6, 16'hFFFF, 1'b0, 1'b0};
    vt[11] = '{1'b1, 16'h8000, 16'h8000, 3'd0, 3'd1, 3'd2, 3'd0, 16'h0000, 1'b1, 1'b1};

    for (int i = 0; i < 8; i++) m_rf[i] = 16'h0000;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_rd = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 16'(cmd_ready), 16'd0);
    chk("rst_rsp_valid", 16'(rsp_valid), 16'd0);
    chk("rst_rsp_data", rsp_data, 16'h0000);
    chk("rst_rsp_rd", 16'(rsp_rd), 16'd0);
    chk("rst_rsp_err", 16'(rsp_err), 16'd0);
    chk("rst_alu_a", alu_a, 16'h0000);
    chk("rst_alu_b", alu_b, 16'h0000);
    chk("rst_alu_control", 16'(alu_control), 16'd0);
`ifdef ALU_ISSUE_FLAGS_EN
    chk("rst_rsp_zero", 16'(rsp_zero), 16'd0);
    chk("rst_rsp_carry", 16'(rsp_carry), 16'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", 16'(cmd_ready), 16'd1);

    // Constant vectors from the plan
    for (int i = 0; i < 12; i++) begin
      if (vt[i].ld) begin load(3'd1, vt[i].a); load(3'd2, vt[i].b); end
      issue(vt[i].op, vt[i].rs1, vt[i].rs2, vt[i].rd, 0, 1'b0, 3'd0, 16'h0000, d, e);
      chk($sformatf("vec%0d_data", i), d, vt[i].exp);
`ifdef ALU_ISSUE_FLAGS_EN
      chk($sformatf("vec%0d_zero", i), 16'(vt[i].z), 16'(vt[i].exp == 16'h0000));
`endif
    end
    issue(3'd3, 3'd0, 3'd0, 3'd7, 0, 1'b0, 3'd0, 16'h0000, d, e);
    chk("r0_reads_zero", d, 16'h0000);

    // Illegal opcode: error response, no writeback
    load(3'd5, 16'h0123);
    issue(3'd6, 3'd1, 3'd2, 3'd5, 0, 1'b0, 3'd0, 16'h0000, d, e);
    chk("illegal_err", 16'(e), 16'd1);
    issue(3'd3, 3'd5, 3'd0, 3'd6, 0, 1'b0, 3'd0, 16'h0000, d, e);
    chk("illegal_no_wb", d, 16'h0123);

    // Back-pressure: held response, ignored command pulse, writeback beats load
    load(3'd1, 16'h1111); load(3'd2, 16'h2222);
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_rs1 = 3'd1; cmd_rs2 = 3'd2; cmd_rd = 3'd3;
    rsp_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("bp_valid0", 16'(rsp_valid), 16'd1);
    chk("bp_data0", rsp_data, 16'h3333);
    for (int k = 0; k < 3; k++) begin
      cmd_valid = (k == 1); cmd_op = 3'd3; cmd_rs1 = 3'd1; cmd_rs2 = 3'd0; cmd_rd = 3'd6;
      @(negedge clk);
      chk("bp_valid", 16'(rsp_valid), 16'd1);
      chk("bp_data", rsp_data, 16'h3333);
      chk("bp_rd", 16'(rsp_rd), 16'd3);
      chk("bp_cmd_ready", 16'(cmd_ready), 16'd0);
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    ld_valid = 1'b1; ld_addr = 3'd3; ld_data = 16'hBEEF;
    @(negedge clk);
    ld_valid = 1'b0;
    chk("bp_hs_valid", 16'(rsp_valid), 16'd0);
    m_rf[3] = 16'h3333;
    issue(3'd3, 3'd3, 3'd0, 3'd4, 0, 1'b0, 3'd0, 16'h0000, d, e);
    chk("wb_beats_load", d, 16'h3333);
    issue(3'd3, 3'd6, 3'd0, 3'd4, 0, 1'b0, 3'd0, 16'h0000, d, e);
    chk("pulse_ignored", d, 16'h0123);

    // Reset during EXEC aborts the command
    load(3'd1, 16'h0F00); load(3'd2, 16'h00F0);
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_rs1 = 3'd1; cmd_rs2 = 3'd2; cmd_rd = 3'd3;
    @(negedge clk);
    cmd_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) m_rf[i] = 16'h0000;
    for (int k = 0; k < 4; k++) begin
      chk("abort_rsp_valid", 16'(rsp_valid), 16'd0);
      @(negedge clk);
    end
    issue(3'd3, 3'd3, 3'd0, 3'd4, 0, 1'b0, 3'd0, 16'h0000, d, e);
    chk("abort_no_wb", d, 16'h0000);

    // Random traffic against the model
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 2) == 0) load(3'($urandom_range(0, 7)), 16'($urandom));
      issue(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), 16'($urandom), d, e);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
